// File: rtl/dac_spi_tx.sv
// dac_spi_tx: buffers 16-bit samples in a small FIFO and sends each one as a 24-bit
// SPI mode-0 frame {CMD_BYTE, data}. Define OFFSET_BINARY_EN to send offset binary.
module dac_spi_tx #(
  parameter int         CLK_DIV  = 2,
  parameter logic [7:0] CMD_BYTE = 8'h30,
  parameter int         FIFO_AW  = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic signed [15:0] sample_in,
  input  logic               sample_valid,
  output logic               dac_sclk,
  output logic               dac_cs_n,
  output logic               dac_mosi,
  output logic               busy,
  output logic               overflow,
  output logic [FIFO_AW:0]   fifo_level
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [FIFO_AW:0] LVL_FULL = (FIFO_AW + 1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  function automatic logic [15:0] fmt_sample(input logic signed [15:0] s);
`ifdef OFFSET_BINARY_EN
    return {~s[15], s[14:0]};
`else
    return s[15:0];
`endif
  endfunction

  logic signed [15:0] r_mem [DEPTH];
  logic [FIFO_AW-1:0] r_wptr;
  logic [FIFO_AW-1:0] r_rptr;
  logic [FIFO_AW:0]   r_count;
  logic               r_ovf;

  state_t           r_state, w_state_nxt;
  logic [23:0]      r_shreg, w_shreg_nxt;
  logic [DIV_W-1:0] r_div, w_div_nxt;
  logic [4:0]       r_bit, w_bit_nxt;
  logic             r_gap, w_gap_nxt;
  logic             r_sclk, w_sclk_nxt;
  logic             r_cs_n, w_cs_n_nxt;
  logic             r_mosi, w_mosi_nxt;
  logic             r_busy, w_busy_nxt;

  logic w_pop;
  logic w_full;
  logic w_push;
  logic w_drop;

  // A pop frees a slot in the same cycle, so a full FIFO still accepts a write then.
  assign w_pop  = (r_state == S_IDLE) && (r_count != '0);
  assign w_full = (r_count == LVL_FULL);
  assign w_push = sample_valid && (!w_full || w_pop);
  assign w_drop = sample_valid && w_full && !w_pop;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= sample_in;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_drop) begin
        r_ovf <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_sclk  <= 1'b0;
      r_cs_n  <= 1'b1;
      r_mosi  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_sclk  <= w_sclk_nxt;
      r_cs_n  <= w_cs_n_nxt;
      r_mosi  <= w_mosi_nxt;
      r_busy  <= w_busy_nxt;
    end
  end

  // Frame datapath: loaded on every pop before use, so no reset needed.
  always_ff @(posedge clk) begin
    r_shreg <= w_shreg_nxt;
    r_div   <= w_div_nxt;
    r_bit   <= w_bit_nxt;
    r_gap   <= w_gap_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_shreg_nxt = r_shreg;
    w_div_nxt   = r_div;
    w_bit_nxt   = r_bit;
    w_gap_nxt   = r_gap;
    w_sclk_nxt  = r_sclk;
    w_cs_n_nxt  = r_cs_n;
    w_mosi_nxt  = r_mosi;
    case (r_state)
      S_IDLE: begin
        if (w_pop) begin
          w_state_nxt = S_SHIFT;
          w_shreg_nxt = {CMD_BYTE, fmt_sample(r_mem[r_rptr])};
          w_mosi_nxt  = CMD_BYTE[7];
          w_cs_n_nxt  = 1'b0;
          w_sclk_nxt  = 1'b0;
          w_div_nxt   = '0;
          w_bit_nxt   = '0;
        end
      end
      S_SHIFT: begin
        if (r_div == DIV_LAST) begin
          w_div_nxt = '0;
          if (!r_sclk) begin
            w_sclk_nxt = 1'b1;
          end else if (r_bit == 5'd23) begin
            w_state_nxt = S_GAP;
            w_cs_n_nxt  = 1'b1;
            w_sclk_nxt  = 1'b0;
            w_mosi_nxt  = 1'b0;
            w_gap_nxt   = 1'b0;
          end else begin
            // Falling edge: present the next bit, MSB first.
            w_sclk_nxt = 1'b0;
            w_bit_nxt  = r_bit + 1'b1;
            w_mosi_nxt = r_shreg[5'd22 - r_bit];
          end
        end else begin
          w_div_nxt = r_div + 1'b1;
        end
      end
      S_GAP: begin
        if (r_gap) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_gap_nxt = 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cs_n_nxt  = 1'b1;
        w_sclk_nxt  = 1'b0;
        w_mosi_nxt  = 1'b0;
      end
    endcase
    w_busy_nxt = (w_state_nxt != S_IDLE);
  end

  assign dac_sclk   = r_sclk;
  assign dac_cs_n   = r_cs_n;
  assign dac_mosi   = r_mosi;
  assign busy       = r_busy;
  assign overflow   = r_ovf;
  assign fifo_level = r_count;

endmodule

// File: tb/tb_dac_spi_tx.sv
// Self-checking bench for dac_spi_tx: vector table, hand-written corner sequences,
// and randomized strobes against a cycle-level queue model of the transmitter.
module tb_dac_spi_tx;

  localparam int         CLK_DIV   = 2;
  localparam int         FIFO_AW   = 2;
  localparam int         DEPTH     = 4;
  localparam logic [7:0] CMD       = 8'h30;
  localparam int         FRAME_CYC = 48 * CLK_DIV;

  logic             clk = 1'b0;
  logic             rst;
  logic [15:0]      sample_in;
  logic             sample_valid;
  logic             dac_sclk, dac_cs_n, dac_mosi, busy, overflow;
  logic [FIFO_AW:0] fifo_level;

  int n_tests = 0;
  int n_fail  = 0;

  dac_spi_tx #(.CLK_DIV(CLK_DIV), .CMD_BYTE(CMD), .FIFO_AW(FIFO_AW)) dut (
    .clk(clk), .rst(rst), .sample_in(sample_in), .sample_valid(sample_valid),
    .dac_sclk(dac_sclk), .dac_cs_n(dac_cs_n), .dac_mosi(dac_mosi),
    .busy(busy), .overflow(overflow), .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  typedef struct { logic [23:0] data; int bits; int low; } frame_t;
  typedef struct { logic [15:0] sample; logic [15:0] data; } vec_t;

  frame_t got_q[$];
  int     d_glitch = 0;

  // SPI receiver: captures MOSI on each observed SCLK rise while CS is low.
  initial begin
    logic in_frame, p_cs, p_sclk, p_mosi;
    logic [23:0] dat;
    int bits, low;
    in_frame = 1'b0; p_cs = 1'b1; p_sclk = 1'b0; p_mosi = 1'b0;
    dat = '0; bits = 0; low = 0;
    forever begin
      @(negedge clk);
      if (rst !== 1'b1) begin
        in_frame = 1'b0;
      end else begin
        if (p_cs === 1'b1 && dac_cs_n === 1'b0) begin
          in_frame = 1'b1; dat = '0; bits = 0; low = 0;
        end
        if (in_frame && dac_cs_n === 1'b0) begin
          low++;
          if (p_sclk === 1'b0 && dac_sclk === 1'b1) begin
            dat = {dat[22:0], dac_mosi};
            bits++;
          end
          if (p_sclk === 1'b1 && dac_sclk === 1'b1 && dac_mosi !== p_mosi) d_glitch++;
        end
        if (in_frame && dac_cs_n === 1'b1) begin
          got_q.push_back('{dat, bits, low});
          in_frame = 1'b0;
        end
      end
      p_cs = dac_cs_n; p_sclk = dac_sclk; p_mosi = dac_mosi;
    end
  end

  function automatic logic [15:0] to_dac(input logic [15:0] s);
`ifdef OFFSET_BINARY_EN
    return s + 16'h8000;
`else
    return s;
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_frames(input int n, input int limit);
    int k;
    k = 0;
    while (got_q.size() < n && k < limit) begin
      tick();
      k++;
    end
  endtask

  task automatic run_single(input logic [15:0] s, input logic [15:0] d, input string nm);
    int k, bcnt, rise;
    frame_t f;
    got_q.delete();
    sample_in = s; sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
    check({nm, "_lvl_written"}, fifo_level, 1);
    check({nm, "_cs_before_pop"}, dac_cs_n, 1);
    tick();
    check({nm, "_cs_fall"}, dac_cs_n, 0);
    check({nm, "_mosi_bit23"}, dac_mosi, CMD[7]);
    bcnt = 0; rise = -1; k = 0;
    while (busy === 1'b1 && k < 400) begin
      if (rise < 0 && dac_sclk === 1'b1) rise = k;
      bcnt++; k++;
      tick();
    end
    check({nm, "_busy_cycles"}, bcnt, FRAME_CYC + 2);
    check({nm, "_first_rise"}, rise, CLK_DIV);
    wait_frames(1, 20);
    check({nm, "_frames"}, got_q.size(), 1);
    if (got_q.size() > 0) begin
      f = got_q.pop_front();
      check({nm, "_data"}, f.data, {CMD, d});
      check({nm, "_bits"}, f.bits, 24);
      check({nm, "_cs_low"}, f.low, FRAME_CYC);
    end
  endtask

  // Reference model state for the randomized phase.
  logic [15:0] m_q[$];
  logic [15:0] m_exp[$];
  logic        m_ovf;
  bit          m_have;
  int          mc, m_last, m_free;

  task automatic rand_run(input int ncyc, input int pdiv, input string nm);
    logic eb, ec, v;
    logic [15:0] s;
    for (int c = 0; c < ncyc; c++) begin
      eb = m_have && (mc > m_last) && (mc < m_free);
      ec = !(m_have && (mc > m_last) && (mc <= m_last + FRAME_CYC));
      check($sformatf("%s_c%0d", nm, c), {busy, dac_cs_n, overflow, fifo_level},
            {eb, ec, m_ovf, 3'(m_q.size())});
      if (pdiv > 0) v = ($urandom_range(pdiv - 1) == 0);
      else v = 1'b0;
      s = 16'($urandom);
      sample_in = s; sample_valid = v;
      if (mc >= m_free && m_q.size() > 0) begin
        m_exp.push_back(m_q.pop_front());
        m_have = 1; m_last = mc; m_free = mc + FRAME_CYC + 3;
      end
      if (v) begin
        if (m_q.size() < DEPTH) m_q.push_back(s);
        else m_ovf = 1'b1;
      end
      tick();
      mc++;
    end
    sample_valid = 1'b0;
  endtask

  initial begin
    vec_t tbl[6];
    logic [15:0] ov[6];
    logic [15:0] mr[3];
    int k, cnt, nchk;
    frame_t f;

`ifdef OFFSET_BINARY_EN
    tbl[0] = '{16'h1234, 16'h9234}; tbl[1] = '{16'h8000, 16'h0000};
    tbl[2] = '{16'h7FFF, 16'hFFFF}; tbl[3] = '{16'hFFFF, 16'h7FFF};
    tbl[4] = '{16'h0000, 16'h8000}; tbl[5] = '{16'hA5C3, 16'h25C3};
`else
    tbl[0] = '{16'h1234, 16'h1234}; tbl[1] = '{16'h8000, 16'h8000};
    tbl[2] = '{16'h7FFF, 16'h7FFF}; tbl[3] = '{16'hFFFF, 16'hFFFF};
    tbl[4] = '{16'h0000, 16'h0000}; tbl[5] = '{16'hA5C3, 16'hA5C3};
`endif
    ov = '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555, 16'h6666};
    mr = '{16'hC001, 16'hC002, 16'hC003};

    // Reset with strobes active.
    rst = 1'b0; sample_valid = 1'b1; sample_in = 16'h5A5A;
    repeat (3) @(posedge clk);
    tick();
    check("rst_cs_n", dac_cs_n, 1);
    check("rst_sclk", dac_sclk, 0);
    check("rst_mosi", dac_mosi, 0);
    check("rst_busy", busy, 0);
    check("rst_overflow", overflow, 0);
    check("rst_level", fifo_level, 0);
    sample_valid = 1'b0; rst = 1'b1;
    repeat (5) tick();
    check("post_rst_busy", busy, 0);
    check("post_rst_cs_n", dac_cs_n, 1);
    check("post_rst_frames", got_q.size(), 0);

    for (int i = 0; i < 6; i++) run_single(tbl[i].sample, tbl[i].data, $sformatf("vec%0d", i));

    // Full FIFO at the end of GAP; strobe in the popping IDLE cycle.
    got_q.delete();
    for (int i = 0; i < 5; i++) begin
      sample_in = ov[i]; sample_valid = 1'b1;
      tick();
    end
    sample_valid = 1'b0;
    check("wp_full_level", fifo_level, 4);
    k = 0;
    while (busy === 1'b1 && k < 400) begin tick(); k++; end
    check("wp_gap_end_cycle", k, FRAME_CYC - 1);
    check("wp_level_at_pop", fifo_level, 4);
    sample_in = ov[5]; sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
    check("wp_level_kept", fifo_level, 4);
    check("wp_no_overflow", overflow, 0);
    check("wp_busy", busy, 1);
    wait_frames(6, 800);
    repeat (20) tick();
    check("wp_frames", got_q.size(), 6);
    nchk = (got_q.size() < 6) ? got_q.size() : 6;
    for (int i = 0; i < nchk; i++) check($sformatf("wp_data%0d", i), got_q[i].data, {CMD, to_dac(ov[i])});

    // Reset during bit 10 of a frame with two samples buffered.
    got_q.delete();
    for (int i = 0; i < 3; i++) begin
      sample_in = mr[i]; sample_valid = 1'b1;
      tick();
    end
    sample_valid = 1'b0;
    check("mr_level_before", fifo_level, 2);
    check("mr_cs_before", dac_cs_n, 0);
    repeat (52) tick();
    rst = 1'b0;
    tick();
    check("mr_cs_n", dac_cs_n, 1);
    check("mr_sclk", dac_sclk, 0);
    check("mr_mosi", dac_mosi, 0);
    check("mr_level", fifo_level, 0);
    check("mr_busy", busy, 0);
    tick();
    rst = 1'b1;
    cnt = 0;
    repeat (200) begin
      if (dac_cs_n !== 1'b1 || busy !== 1'b0) cnt++;
      tick();
    end
    check("mr_no_resume", cnt, 0);
    check("mr_no_frames", got_q.size(), 0);
    run_single(16'h0F0F, to_dac(16'h0F0F), "mr_new");

    // Six back-to-back strobes from IDLE.
    got_q.delete();
    for (int i = 0; i < 6; i++) begin
      sample_in = ov[i]; sample_valid = 1'b1;
      tick();
      check($sformatf("ov_level%0d", i), fifo_level, (i < 2) ? 1 : ((i > 4) ? 4 : i));
      check($sformatf("ov_flag%0d", i), overflow, (i == 5) ? 1 : 0);
    end
    sample_valid = 1'b0;
    wait_frames(5, 700);
    repeat (150) tick();
    check("ov_frames", got_q.size(), 5);
    nchk = (got_q.size() < 5) ? got_q.size() : 5;
    for (int i = 0; i < nchk; i++) check($sformatf("ov_data%0d", i), got_q[i].data, {CMD, to_dac(ov[i])});
    check("ov_sticky", overflow, 1);
    check("ov_level_end", fifo_level, 0);

    rst = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
    tick();
    check("ov_cleared", overflow, 0);

    // Randomized traffic against the model.
    got_q.delete();
    m_q.delete(); m_exp.delete();
    m_ovf = 1'b0; m_have = 0; mc = 0; m_last = 0; m_free = 0;
    rand_run(2500, 150, "rlo");
    rand_run(1500, 20, "rhi");
    rand_run(700, 0, "rdrain");
    check("rand_frames", got_q.size(), m_exp.size());
    nchk = (got_q.size() < m_exp.size()) ? got_q.size() : m_exp.size();
    for (int i = 0; i < nchk; i++) begin
      f = got_q[i];
      check($sformatf("rand_data%0d", i), f.data, {CMD, to_dac(m_exp[i])});
      check($sformatf("rand_bits%0d", i), f.bits, 24);
    end
    check("mosi_stable_sclk_high", d_glitch, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
